if_fetch_unit: RTL

- Instruction-fetch stage directly upstream of the IF/ID pipeline register.
- Owns the 30-bit word-address PC and issues requests to a variable-latency instruction memory using a req/ready handshake.
- Produces `if_ins`, `pc_plus_4` and `if_valid` for IF/ID, honours `hazard` stalls, and redirects on taken branch, jump and jalr.
- Discards any wrong-path fetch that is still in flight when a redirect arrives.

---
 rtl/if_fetch_unit.sv | 126 ++++++++++++
 1 files changed

// File: rtl/if_fetch_unit.sv
// Instruction fetch: owns the word PC and fetches over a req/ready imem port, feeding IF/ID one cycle after completion.
// Backpressure: a hazard holds the PC and outputs, and a word that arrives during a hazard is parked in a one-entry buffer.
module if_fetch_unit #(
  parameter logic [29:0] RESET_PC = 30'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hazard,
  input  logic        branch_taken,
  input  logic [29:0] branch_target,
  input  logic        jump,
  input  logic [29:0] jump_target,
  input  logic        jalr,
  input  logic [29:0] jalr_target,
  output logic        imem_req,
  output logic [29:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] if_ins,
  output logic [29:0] pc_plus_4,
  output logic        if_valid
);

  typedef enum logic [1:0] {
    S_REQ   = 2'd0,
    S_HOLD  = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t      state;
  logic [29:0] pc;
  logic [29:0] pc_inc;
  logic [31:0] buf_ins;
  logic        buf_valid;
  logic [29:0] pend_target;
  logic        redirect;
  logic [29:0] redir_target;

  assign pc_inc    = pc + 30'd1;
  assign redirect  = (jalr | jump | branch_taken) & ~hazard;
  assign imem_req  = rst_n & (state != S_HOLD);
  assign imem_addr = pc;

  always_comb begin
    redir_target = branch_target;
    if (jalr)
      redir_target = jalr_target;
    else if (jump)
      redir_target = jump_target;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_REQ;
      pc          <= RESET_PC;
      if_ins      <= 32'd0;
      pc_plus_4   <= 30'd0;
      if_valid    <= 1'b0;
      buf_ins     <= 32'd0;
      buf_valid   <= 1'b0;
      pend_target <= 30'd0;
    end else begin
      case (state)
        S_REQ: begin
          if (imem_ready) begin
            if (redirect) begin
              pc        <= redir_target;
              if_ins    <= 32'd0;
              if_valid  <= 1'b0;
              pc_plus_4 <= pc_inc;
            end else if (hazard) begin
              buf_ins   <= imem_rdata;
              buf_valid <= 1'b1;
              state     <= S_HOLD;
            end else begin
              if_ins    <= imem_rdata;
              pc_plus_4 <= pc_inc;
              if_valid  <= 1'b1;
              pc        <= pc_inc;
            end
          end else if (redirect) begin
            // Fetch already issued on the old path; wait it out before moving pc.
            pend_target <= redir_target;
            if_ins      <= 32'd0;
            if_valid    <= 1'b0;
            state       <= S_DRAIN;
          end else if (!hazard) begin
            if_ins   <= 32'd0;
            if_valid <= 1'b0;
          end
        end

        S_HOLD: begin
          if (!hazard) begin
            buf_valid <= 1'b0;
            state     <= S_REQ;
            if (redirect) begin
              pc       <= redir_target;
              if_ins   <= 32'd0;
              if_valid <= 1'b0;
            end else begin
              if_ins    <= buf_ins;
              pc_plus_4 <= pc_inc;
              if_valid  <= buf_valid;
              pc        <= pc_inc;
            end
          end
        end

        S_DRAIN: begin
          if_ins   <= 32'd0;
          if_valid <= 1'b0;
          if (imem_ready) begin
            pc    <= redirect ? redir_target : pend_target;
            state <= S_REQ;
          end else if (redirect) begin
            pend_target <= redir_target;
          end
        end

        default: state <= S_REQ;
      endcase
    end
  end

endmodule
